// File: rtl/rft_pkg.sv
// rtl/rft_pkg.sv - shared record kinds, dump FSM states and record field offsets for the trace monitor
package rft_pkg;

   localparam logic KIND_WRITE = 1'b0;
   localparam logic KIND_DUMP  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DUMP  = 2'd1,
      ST_DRAIN = 2'd2
   } dump_state_t;

   // Record layout, LSB first: data, addr, cycle, kind
   function automatic int rec_width(input int xlen, input int aw, input int cycle_w);
      return 1 + cycle_w + aw + xlen;
   endfunction

   function automatic int data_lsb();
      return 0;
   endfunction

   function automatic int addr_lsb(input int xlen);
      return xlen;
   endfunction

   function automatic int cycle_lsb(input int xlen, input int aw);
      return xlen + aw;
   endfunction

   function automatic int kind_bit(input int xlen, input int aw, input int cycle_w);
      return xlen + aw + cycle_w;
   endfunction

endpackage

// File: rtl/rft_fifo.sv
// rtl/rft_fifo.sv - show-ahead synchronous FIFO; head is forced to zero while empty
module rft_fifo #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [WIDTH-1:0]   push_data,
   input  logic               pop,
   output logic [WIDTH-1:0]   pop_data,
   output logic               full,
   output logic               empty,
   output logic [LEVEL_W-1:0] level
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [LEVEL_W-1:0] count;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count == LEVEL_W'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   // A push into a full FIFO is legal when the head leaves on the same edge
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + LEVEL_W'(1);
            2'b01:   count <= count - LEVEL_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/regfile_trace_monitor.sv
// rtl/regfile_trace_monitor.sv - register-file write tracer with shadow copy, cycle stamps and snapshot dump
// Optional RFT_DIFF_FILTER_EN: suppress tracing of writes that leave the shadow value unchanged.
module regfile_trace_monitor
   import rft_pkg::*;
#(
   parameter  int XLEN     = 32,
   parameter  int NUM_REGS = 32,
   parameter  int DEPTH    = 8,
   parameter  int CYCLE_W  = 32,
   localparam int AW       = $clog2(NUM_REGS),
   localparam int REC_W    = rec_width(XLEN, AW, CYCLE_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [XLEN-1:0]    wr_data,
   input  logic               dump_req,
   output logic               dump_busy,
   output logic               trc_valid,
   input  logic               trc_ready,
   output logic [REC_W-1:0]   trc_data,
   output logic [AW:0]        fifo_level,
   output logic [15:0]        drop_count,
   output logic [CYCLE_W-1:0] cycle_count
);

   localparam int DATA_LSB = data_lsb();
   localparam int ADDR_LSB = addr_lsb(XLEN);
   localparam int CYC_LSB  = cycle_lsb(XLEN, AW);
   localparam int KIND_POS = kind_bit(XLEN, AW, CYCLE_W);

   logic [XLEN-1:0]    shadow [NUM_REGS];
   logic [CYCLE_W-1:0] cycle_q;
   logic [15:0]        drop_q;
   dump_state_t        state_q, state_d;
   logic [AW-1:0]      idx_q;
   logic               wr_event, trace_event;
   logic               pop, can_push, push_wr, push_dump, push;
   logic               fifo_full, fifo_empty, dump_last;
   logic [REC_W-1:0]   push_data;

   assign wr_event = wr_en && (wr_addr != '0) && (32'(wr_addr) < NUM_REGS);
`ifdef RFT_DIFF_FILTER_EN
   assign trace_event = wr_event && (wr_data != shadow[wr_addr]);
`else
   assign trace_event = wr_event;
`endif

   assign pop       = !fifo_empty && trc_ready;
   assign can_push  = !fifo_full || pop;
   // Write events win the single push slot; the dump entry simply waits
   assign push_wr   = trace_event && can_push;
   assign push_dump = (state_q == ST_DUMP) && !trace_event && can_push;
   assign push      = push_wr || push_dump;
   assign dump_last = (idx_q == AW'(NUM_REGS - 1));

   always_comb begin
      push_data = '0;
      push_data[KIND_POS]            = push_wr ? KIND_WRITE : KIND_DUMP;
      push_data[CYC_LSB +: CYCLE_W]  = cycle_q;
      push_data[ADDR_LSB +: AW]      = push_wr ? wr_addr : idx_q;
      push_data[DATA_LSB +: XLEN]    = push_wr ? wr_data : shadow[idx_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q <= '0;
         drop_q  <= '0;
         state_q <= ST_IDLE;
         idx_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      end else begin
         cycle_q <= cycle_q + CYCLE_W'(1);
         state_q <= state_d;
         if (trace_event && !can_push && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         if (wr_event) shadow[wr_addr] <= wr_data;
         if (state_q == ST_IDLE && dump_req) idx_q <= '0;
         else if (push_dump)                 idx_q <= idx_q + AW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (dump_req)               state_d = ST_DUMP;
         ST_DUMP:  if (push_dump && dump_last) state_d = ST_DRAIN;
         ST_DRAIN: if (fifo_empty)             state_d = ST_IDLE;
         default:                              state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dump_busy = (state_q != ST_IDLE);
   end

   rft_fifo #(
      .WIDTH   (REC_W),
      .DEPTH   (DEPTH),
      .LEVEL_W (AW + 1)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (trc_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign trc_valid   = !fifo_empty;
   assign drop_count  = drop_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_regfile_trace_monitor.sv
// tb/tb_regfile_trace_monitor.sv - directed self-checking bench for regfile_trace_monitor
module tb_regfile_trace_monitor;

   localparam int XLEN = 32, NUM_REGS = 32, DEPTH = 8, CYCLE_W = 32, AW = 5;
   localparam int REC_W = 1 + CYCLE_W + AW + XLEN;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               wr_en = 1'b0;
   logic [AW-1:0]      wr_addr = '0;
   logic [XLEN-1:0]    wr_data = '0;
   logic               dump_req = 1'b0;
   logic               trc_ready = 1'b0;
   logic               dump_busy, trc_valid;
   logic [REC_W-1:0]   trc_data;
   logic [AW:0]        fifo_level;
   logic [15:0]        drop_count;
   logic [CYCLE_W-1:0] cycle_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [REC_W-1:0] log_q[$];

   always #5 clk = ~clk;

   regfile_trace_monitor #(
      .XLEN(XLEN), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .CYCLE_W(CYCLE_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dump_req(dump_req), .dump_busy(dump_busy), .trc_valid(trc_valid), .trc_ready(trc_ready),
      .trc_data(trc_data), .fifo_level(fifo_level), .drop_count(drop_count), .cycle_count(cycle_count)
   );

   // Records handed over at the following rising edge
   always @(negedge clk) begin
      if (rst_n && trc_valid && trc_ready) log_q.push_back(trc_data);
   end

   function automatic logic [REC_W-1:0] rec(input logic k, input logic [CYCLE_W-1:0] c,
                                            input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      return {k, c, a, d};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wr_en = 1'b0; dump_req = 1'b0; trc_ready = 1'b0;
      tick(2);
      rst_n = 1'b1;
      log_q.delete();
   endtask

   task automatic wait_idle(input int max);
      for (int n = 0; n < max && dump_busy; n++) tick(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFF; dump_req = 1'b1; trc_ready = 1'b1;
      tick(2);
      n_tests++; if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", trc_valid); end
      n_tests++; if (trc_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", trc_data); end
      n_tests++; if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", dump_busy); end
      n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      n_tests++; if (drop_count !== '0) begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
      n_tests++; if (cycle_count !== '0) begin n_fail++; $display("FAIL reset_cycle got=%0d exp=0", cycle_count); end
      wr_en = 1'b0; dump_req = 1'b0; trc_ready = 1'b0;
      rst_n = 1'b1;
      tick(1);
      n_tests++; if (cycle_count !== 32'd1) begin n_fail++; $display("FAIL cycle_after_release got=%0d exp=1", cycle_count); end
   endtask

   task automatic test_single_write();
      do_reset();
      tick(3);
      n_tests++; if (cycle_count !== 32'd3) begin n_fail++; $display("FAIL sw_cycle got=%0d exp=3", cycle_count); end
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      n_tests++; if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL sw_valid_early got=%b exp=0", trc_valid); end
      tick(1);
      wr_en = 1'b0;
      n_tests++; if (trc_valid !== 1'b1) begin n_fail++; $display("FAIL sw_valid got=%b exp=1", trc_valid); end
      n_tests++; if (trc_data !== rec(1'b0, 32'd3, 5'd5, 32'hDEADBEEF)) begin n_fail++; $display("FAIL sw_data got=%h exp=%h", trc_data, rec(1'b0, 32'd3, 5'd5, 32'hDEADBEEF)); end
      n_tests++; if (fifo_level !== 6'd1) begin n_fail++; $display("FAIL sw_level got=%0d exp=1", fifo_level); end
      trc_ready = 1'b1;
      tick(1);
      trc_ready = 1'b0;
      n_tests++; if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL sw_drained got=%b exp=0", trc_valid); end
   endtask

   task automatic test_ignored_writes();
      do_reset();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      tick(2);
      wr_en = 1'b0;
      tick(1);
      n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL x0_level got=%0d exp=0", fifo_level); end
      n_tests++; if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL x0_valid got=%b exp=0", trc_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i + 1); wr_data = 32'(100 + i);
         tick(1);
      end
      wr_en = 1'b0;
      n_tests++; if (fifo_level !== 6'd8) begin n_fail++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
      n_tests++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
      n_tests++; if (trc_data !== rec(1'b0, 32'd0, 5'd1, 32'd100)) begin n_fail++; $display("FAIL ovf_head_stable got=%h exp=%h", trc_data, rec(1'b0, 32'd0, 5'd1, 32'd100)); end
      trc_ready = 1'b1;
      for (int n = 0; n < 20 && fifo_level != 0; n++) tick(1);
      n_tests++; if (log_q.size() !== 8) begin n_fail++; $display("FAIL ovf_count got=%0d exp=8", log_q.size()); end
      for (int i = 0; i < 8 && i < log_q.size(); i++) begin
         n_tests++;
         if (log_q[i] !== rec(1'b0, 32'(i), AW'(i + 1), 32'(100 + i))) begin
            n_fail++; $display("FAIL ovf_rec%0d got=%h exp=%h", i, log_q[i], rec(1'b0, 32'(i), AW'(i + 1), 32'(100 + i)));
         end
      end
      n_tests++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_hold got=%0d exp=2", drop_count); end
      trc_ready = 1'b0;
   endtask

   task automatic test_dump();
      logic [REC_W-1:0] r;
      do_reset();
      trc_ready = 1'b1;
      for (int i = 1; i < NUM_REGS; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'(i * 3);
         tick(1);
      end
      wr_addr = 5'd0; wr_data = 32'h1234;
      tick(1);
      wr_en = 1'b0;
      tick(2);
      log_q.delete();
      dump_req = 1'b1;
      tick(1);
      dump_req = 1'b0;
      n_tests++; if (dump_busy !== 1'b1) begin n_fail++; $display("FAIL dump_busy_rise got=%b exp=1", dump_busy); end
      tick(3);
      dump_req = 1'b1;
      tick(1);
      dump_req = 1'b0;
      wait_idle(100);
      n_tests++; if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL dump_busy_fall got=%b exp=0", dump_busy); end
      n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL dump_level_at_idle got=%0d exp=0", fifo_level); end
      tick(3);
      n_tests++; if (log_q.size() !== NUM_REGS) begin n_fail++; $display("FAIL dump_count got=%0d exp=%0d", log_q.size(), NUM_REGS); end
      for (int i = 0; i < NUM_REGS && i < log_q.size(); i++) begin
         r = log_q[i];
         n_tests++;
         if ({r[REC_W-1], r[AW+XLEN-1:0]} !== {1'b1, AW'(i), 32'(i * 3)}) begin
            n_fail++; $display("FAIL dump_rec%0d got=%h exp kind=1 addr=%0d data=%h", i, r, i, 32'(i * 3));
         end
      end
      trc_ready = 1'b0;
   endtask

   task automatic test_dump_with_writes();
      logic [REC_W-1:0] r;
      logic [AW+XLEN:0] exp_q[$];
      do_reset();
      trc_ready = 1'b1;
      dump_req = 1'b1;
      tick(1);
      dump_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wr_en = 1'b1; wr_addr = AW'(20 + k); wr_data = 32'hA000 + 32'(k);
         tick(1);
         wr_en = 1'b0;
         tick(1);
      end
      wait_idle(100);
      n_tests++; if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL dww_busy_fall got=%b exp=0", dump_busy); end
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({1'b0, AW'(20 + k), 32'hA000 + 32'(k)});
         exp_q.push_back({1'b1, AW'(k), 32'd0});
      end
      for (int i = 4; i < NUM_REGS; i++)
         exp_q.push_back({1'b1, AW'(i), (i >= 20 && i <= 23) ? 32'hA000 + 32'(i - 20) : 32'd0});
      n_tests++; if (log_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL dww_count got=%0d exp=%0d", log_q.size(), exp_q.size()); end
      for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
         r = log_q[j];
         n_tests++;
         if ({r[REC_W-1], r[AW+XLEN-1:0]} !== exp_q[j]) begin
            n_fail++; $display("FAIL dww_rec%0d got=%h exp={kind,addr,data}=%h", j, {r[REC_W-1], r[AW+XLEN-1:0]}, exp_q[j]);
         end
      end
      trc_ready = 1'b0;
   endtask

   task automatic test_diff_filter();
      int exp_n;
`ifdef RFT_DIFF_FILTER_EN
      exp_n = 1;
`else
      exp_n = 2;
`endif
      do_reset();
      trc_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd5;
      tick(2);
      wr_en = 1'b0;
      tick(3);
      n_tests++; if (log_q.size() !== exp_n) begin n_fail++; $display("FAIL filter_count got=%0d exp=%0d", log_q.size(), exp_n); end
      n_tests++; if (drop_count !== '0) begin n_fail++; $display("FAIL filter_drop got=%0d exp=0", drop_count); end
      trc_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd77; dump_req = 1'b1;
      tick(1);
      wr_en = 1'b0; dump_req = 1'b0;
      n_tests++; if (dump_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", dump_busy); end
      n_tests++; if (trc_data !== rec(1'b0, 32'd0, 5'd3, 32'd77)) begin n_fail++; $display("FAIL b2b_write_first got=%h exp=%h", trc_data, rec(1'b0, 32'd0, 5'd3, 32'd77)); end
      tick(1);
      n_tests++; if (fifo_level !== 6'd2) begin n_fail++; $display("FAIL b2b_level got=%0d exp=2", fifo_level); end
      tick(2);
      rst_n = 1'b0;
      #1;
      n_tests++; if ({trc_valid, dump_busy} !== 2'b00) begin n_fail++; $display("FAIL midreset_flags got=%b exp=00", {trc_valid, dump_busy}); end
      n_tests++; if (trc_data !== '0) begin n_fail++; $display("FAIL midreset_data got=%h exp=0", trc_data); end
      n_tests++; if ({fifo_level, drop_count, cycle_count} !== '0) begin n_fail++; $display("FAIL midreset_counters got=%h exp=0", {fifo_level, drop_count, cycle_count}); end
      tick(1);
      rst_n = 1'b1;
      log_q.delete();
      trc_ready = 1'b1;
      tick(5);
      n_tests++; if (log_q.size() !== 0) begin n_fail++; $display("FAIL midreset_no_partial got=%0d exp=0", log_q.size()); end
      n_tests++; if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got=%b exp=0", dump_busy); end
      trc_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_ignored_writes();
      test_overflow();
      test_dump();
      test_dump_with_writes();
      test_diff_filter();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
